sqrt_arbiter: RTL

SQRT_ARBITER -- requirements
Module: sqrt_arbiter

---
 rtl/sqrt_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter
//   Two-requester round-robin front end for a multi-cycle square-root
//   datapath. A grant latches the winner's operands, pulses dp_start, waits
//   for dp_done (bounded by TIMEOUT cycles), and then returns a one-cycle
//   ack to the winner. A timeout returns 8'h00 with err=1 and bumps a
//   saturating error counter.
//
//   Ports
//     clk, rst             clock, synchronous active-high reset
//     req0/req1            level requests, held until ack
//     a0,b0 / a1,b1        operands of requester 0 / 1
//     ack0/ack1            one-cycle completion pulses
//     res, err             response data and timeout flag (valid with ack)
//     err_cnt              saturating timeout count
//     dp_start,dp_a,dp_b   datapath launch and latched operands
//     dp_done,dp_result    datapath completion and result
//     busy, state          status / debug
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | wait for a request, arbitrate, latch operands
//   START | dp_start pulse, clear timeout counter
//   WAIT  | wait for dp_done or timeout
//   RESP  | issue ack (registered, visible in the following cycle)
module sqrt_arbiter #(
  parameter int TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] res,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic       dp_start,
  output logic [7:0] dp_a,
  output logic [7:0] dp_b,
  input  logic       dp_done,
  input  logic [7:0] dp_result,
  output logic       busy,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;
  logic          gid;       // id of the requester being served
  logic          last;      // last-granted pointer
  logic          resp_err;  // outcome of the current operation
  logic          win;

  // On a tie the winner is the id that was not granted last.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) win = ~last;
    else              win = req1;
  end

  assign dp_start = (state == S_START);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      gid      <= 1'b0;
      last     <= 1'b1;
      resp_err <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err      <= 1'b0;
      res      <= 8'h00;
      err_cnt  <= 8'h00;
      dp_a     <= 8'h00;
      dp_b     <= 8'h00;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            gid   <= win;
            dp_a  <= win ? a1 : a0;
            dp_b  <= win ? b1 : b0;
            state <= S_START;
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // dp_done takes priority over a simultaneous terminal count
          if (dp_done) begin
            res      <= dp_result;
            resp_err <= 1'b0;
            state    <= S_RESP;
          end else if (cnt == TC) begin
            res      <= 8'h00;
            resp_err <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            state    <= S_RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP: begin
          ack0  <= ~gid;
          ack1  <= gid;
          err   <= resp_err;
          last  <= gid;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
